mod_divider_seq: RTL and testbench
==================================

# mod_divider_seq

Sequential restoring divider that answers the start/ready request from the modular-exponentiation datapath. It takes one dividend/divisor pair per request, resolves one quotient bit per clock, and returns quotient and remainder with `ready` high. The modexp controller uses it for every `% prime` reduction. It is a single-clock synchronous block with no combinational path from inputs to outputs.

## Interface
- `WIDTH`, default 16, operand and result width in bits.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe, sampled only while `ready`=1.
- `dividend`  input  WIDTH  unsigned dividend, sampled on the accepting edge.
- `divider`  input  WIDTH  unsigned divisor, sampled on the accepting edge.
- `quotient`  output  WIDTH  registered unsigned quotient of the last completed request.
- `remainder`  output  WIDTH  registered unsigned remainder of the last completed request.
- `ready`  output  1  high = idle, results valid, new request accepted.
- `div_by_zero`  output  1  high when the last completed request had `divider`=0.

## Operation
- Reset values: `ready`=1, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, iteration counter 0.
- States:
  - IDLE: `ready`=1. On an edge with `start`=1, latch `dividend` into the shift register and `divider` into the divisor register. Clear the partial remainder. Load counter = WIDTH. Drop `ready` and go to RUN.
  - RUN: `ready`=0. Each edge runs one restoring step:
    - partial remainder P (WIDTH+1 bits) = {P, MSB of dividend shift register}.
    - Shift the dividend register left by one.
    - If P ≥ divisor: P -= divisor and the new quotient bit is 1. Otherwise the bit is 0 and P is unchanged.
    - Shift the quotient bit into the LSB of the quotient shift register.
    - Decrement the counter.
  - On the RUN edge where the counter goes 1→0:
    - Write the final quotient to `quotient` and P[WIDTH-1:0] to `remainder`.
    - Set `div_by_zero` = (latched divisor == 0).
    - Raise `ready` and return to IDLE.
- Divide by zero needs no special path. The restoring algorithm gives `quotient` = all ones and `remainder` = dividend. Latency is unchanged.
- `quotient`, `remainder` and `div_by_zero` change only at completion. They hold their values through the next request until that request completes.
- `start` while `ready`=0 is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- `start` is level-sampled. If it is still high on the first IDLE edge after completion, a new request is accepted using the operands present on that edge.
- `dividend` < `divider` gives quotient 0 and remainder = dividend. `dividend` = 0 gives 0/0 (flag clear when the divisor is nonzero).
- Reset has priority over everything. Reset during RUN aborts the operation, forces all outputs to their reset values, and drops any accepted request.

## Timing
- Accepting edge N (IDLE, `start`=1): `ready` is 0 from after edge N.
- Iteration edges: N+1 … N+WIDTH.
- Results and `ready`=1 are visible after edge N+WIDTH, so `ready` is low for exactly WIDTH cycles.
- Earliest next accept: edge N+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- Operand inputs may change freely after the accepting edge.
- The requester must capture outputs while `ready`=1. They stay stable until the next completion.

## Test plan
- Basic divide: reset, then `dividend`=100, `divider`=7, `start` pulsed 1 cycle.
  - `ready` low exactly 16 cycles, then `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Extremes: 0xFFFF/1 → `quotient`=0xFFFF, `remainder`=0. Then 5/9 → `quotient`=0, `remainder`=5. Then 0xFFFF/0xFFFF → 1, 0.
- Divide by zero: 1234/0 → `quotient`=0xFFFF, `remainder`=1234, `div_by_zero`=1. A following 9/3 → 3, 0, flag cleared.
- Busy ignore:
  - Start 1000/10.
  - At cycle 5, pulse `start` with 7/2.
  - Result is 100, 0. `ready` rises once, after cycle 16, and no second operation follows.
- Held start:
  - Hold `start`=1 with 50/6, then switch operands to 81/9 on the completion cycle.
  - First result 8, 2. Second request accepted at N+17, giving 9, 0 after another 16 cycles.
- Reset mid-operation:
  - Start 999/4, assert `rst` for 1 cycle at iteration 8.
  - Next edge shows `ready`=1, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - A fresh 999/4 then gives 249, 3.

Source files
------------

// File: rtl/mod_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/ready handshake,
// registered quotient/remainder/div_by_zero updated only when a request completes.
module mod_divider_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q;     // dividend shift register, consumed MSB first
    logic [WIDTH-1:0] dvs_q;     // latched divisor
    logic [WIDTH-1:0] p_q;       // partial remainder, always < divisor between steps
    logic [WIDTH-1:0] q_sh_q;    // quotient shift register
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_sh_next;
    logic             q_bit;
    logic             last;

    // One restoring step; with a zero divisor every bit subtracts nothing, so the
    // quotient fills with ones and the remainder accumulates the dividend.
    always_comb begin
        p_shift   = {p_q, dvd_q[WIDTH-1]};
        q_bit     = (p_shift >= {1'b0, dvs_q});
        p_next    = q_bit ? WIDTH'(p_shift - {1'b0, dvs_q}) : p_shift[WIDTH-1:0];
        q_sh_next = {q_sh_q[WIDTH-2:0], q_bit};
    end

    assign last  = (cnt_q == CW'(1));
    assign ready = (state_q == IDLE);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            p_q         <= '0;
            q_sh_q      <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q  <= dividend;
                        dvs_q  <= divider;
                        p_q    <= '0;
                        q_sh_q <= '0;
                        cnt_q  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                    p_q    <= p_next;
                    q_sh_q <= q_sh_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last) begin
                        quotient    <= q_sh_next;
                        remainder   <= p_next;
                        div_by_zero <= (dvs_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_divider_seq.sv
// Scoreboard bench for mod_divider_seq: expected results queued at request time,
// popped and compared when ready rises.
module tb_mod_divider_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divider;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    mod_divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divider     (divider),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endfunction

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else               e = 'x;
    endtask

    // Counts edges until ready is seen high; a timeout leaves cycles at 100.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Drives one request for a single cycle; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divider  = b;
        start    = 1'b1;
        push_exp(a, b);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divider  = '0;
        tick();
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got q=%0h r=%0h dz=%b exp all zero", quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int   c;
        exp_t e;
        issue(16'd100, 16'd7);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy ready got=%b exp=0", ready);
        end
        wait_ready(c);
        checks++;
        if (c !== 16) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=16", c);
        end
        pop_exp(e);
        checks++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] a [3] = '{16'hFFFF, 16'd5, 16'hFFFF};
        logic [W-1:0] b [3] = '{16'd1,    16'd9, 16'hFFFF};
        int   c;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(a[i], b[i]);
            wait_ready(c);
            checks++;
            if (c !== 16) begin
                failures++;
                $display("FAIL extremes_latency[%0d] got=%0d exp=16", i, c);
            end
            pop_exp(e);
            checks++;
            if ({quotient, remainder, div_by_zero} !== e) begin
                failures++;
                $display("FAIL extremes_result[%0d] got q=%0h r=%0h dz=%b exp q=%0h r=%0h dz=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] a [2] = '{16'd1234, 16'd9};
        logic [W-1:0] b [2] = '{16'd0,    16'd3};
        int   c;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(a[i], b[i]);
            wait_ready(c);
            checks++;
            if (c !== 16) begin
                failures++;
                $display("FAIL div_zero_latency[%0d] got=%0d exp=16", i, c);
            end
            pop_exp(e);
            checks++;
            if ({quotient, remainder, div_by_zero} !== e) begin
                failures++;
                $display("FAIL div_zero_result[%0d] got q=%0h r=%0d dz=%b exp q=%0h r=%0d dz=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int   c;
        int   low;
        exp_t e;
        issue(16'd1000, 16'd10);
        for (int i = 0; i < 4; i++) tick();
        dividend = 16'd7;
        divider  = 16'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(c);
        checks++;
        if (c + 5 !== 16) begin
            failures++;
            $display("FAIL busy_latency got=%0d exp=16", c + 5);
        end
        pop_exp(e);
        checks++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            failures++;
            $display("FAIL busy_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready !== 1'b1) low++;
        end
        checks++;
        if (low !== 0) begin
            failures++;
            $display("FAIL busy_no_second_op ready low cycles got=%0d exp=0", low);
        end
    endtask

    task automatic test_held_start();
        int   c;
        exp_t e;
        exp_t first;
        dividend = 16'd50;
        divider  = 16'd6;
        start    = 1'b1;
        push_exp(16'd50, 16'd6);
        tick();
        wait_ready(c);
        checks++;
        if (c !== 16) begin
            failures++;
            $display("FAIL held_latency1 got=%0d exp=16", c);
        end
        pop_exp(first);
        checks++;
        if ({quotient, remainder, div_by_zero} !== first) begin
            failures++;
            $display("FAIL held_result1 got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, first.q, first.r, first.dz);
        end
        dividend = 16'd81;
        divider  = 16'd9;
        push_exp(16'd81, 16'd9);
        tick();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL held_reaccept ready got=%b exp=0", ready);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if ({quotient, remainder, div_by_zero} !== first) begin
            failures++;
            $display("FAIL held_outputs_hold got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, first.q, first.r, first.dz);
        end
        wait_ready(c);
        checks++;
        if (c + 8 !== 16) begin
            failures++;
            $display("FAIL held_latency2 got=%0d exp=16", c + 8);
        end
        pop_exp(e);
        checks++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            failures++;
            $display("FAIL held_result2 got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_reset_mid();
        int   c;
        exp_t e;
        issue(16'd999, 16'd4);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready got=%b exp=1", ready);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got q=%0d r=%0d dz=%b exp all zero", quotient, remainder, div_by_zero);
        end
        tick();
        issue(16'd999, 16'd4);
        wait_ready(c);
        checks++;
        if (c !== 16) begin
            failures++;
            $display("FAIL reset_mid_latency got=%0d exp=16", c);
        end
        pop_exp(e);
        checks++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            failures++;
            $display("FAIL reset_mid_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_busy_ignore();
        test_held_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
